// File: rtl/frame_draw_sequencer_pkg.sv
// Shared types and constants for the frame draw sequencer: FSM states,
// default screen geometry and colours, and frame-length helpers.
package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PISTON,
    ST_PART0,
    ST_PART1,
    ST_PART2,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_SCREEN_W  = 320;
  localparam int unsigned DEF_SCREEN_H  = 240;
  localparam int unsigned DEF_PISTON_W  = 220;
  localparam int unsigned DEF_PISTON_X0 = 50;
  localparam int unsigned DEF_PART_SIZE = 19;

  localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;
  localparam logic [2:0] DEF_PISTON_COLOUR = 3'b111;
  localparam logic [2:0] DEF_PART_COLOUR   = 3'b100;

  localparam int unsigned CLEAR_CYCLES = 76800;
  localparam int unsigned PART_CYCLES  = 361;

  // Cycles from the first presented pixel to the last one, default geometry.
  function automatic int unsigned frame_cycles(input int unsigned height);
    int unsigned h;
    h = (height > DEF_SCREEN_H) ? DEF_SCREEN_H : height;
    return CLEAR_CYCLES + DEF_PISTON_W * h + 3 * PART_CYCLES;
  endfunction

endpackage

// File: rtl/frame_draw_sequencer_if.sv
// Bundle between the simulation logic / VGA adapter side and the draw
// sequencer: frame request, latched scene inputs and the pixel stream.
interface frame_draw_sequencer_if;
  logic        start;
  logic [7:0]  piston_height;
  logic [26:0] part_x;
  logic [23:0] part_y;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, piston_height, part_x, part_y,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, piston_height, part_x, part_y,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/frame_draw_sequencer_rect_scanner.sv
// Up-counting raster scan over a w x h rectangle, x fastest. Wraps to (0,0)
// after the last pixel so consecutive rectangles follow without a gap.
module rect_scanner (
  input  logic       clock,
  input  logic       clear,
  input  logic       restart,
  input  logic       enable,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [8:0] sx,
  output logic [7:0] sy,
  output logic       last
);

  logic col_last;
  logic row_last;

  assign col_last = (sx == w - 9'd1);
  assign row_last = (sy == h - 8'd1);
  assign last     = col_last && row_last;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear || restart) begin
      sx <= '0;
      sy <= '0;
    end else if (enable) begin
      if (col_last) begin
        sx <= '0;
        sy <= row_last ? 8'd0 : sy + 8'd1;
      end else begin
        sx <= sx + 9'd1;
      end
    end
  end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Frame draw controller: clears the screen, paints the piston, then three
// particles, one registered pixel per clock toward the VGA adapter.
module frame_draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned SCREEN_W      = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H      = DEF_SCREEN_H,
  parameter int unsigned PISTON_W      = DEF_PISTON_W,
  parameter int unsigned PISTON_X0     = DEF_PISTON_X0,
  parameter int unsigned PART_SIZE     = DEF_PART_SIZE,
  parameter logic [2:0]  BG_COLOUR     = DEF_BG_COLOUR,
  parameter logic [2:0]  PISTON_COLOUR = DEF_PISTON_COLOUR,
  parameter logic [2:0]  PART_COLOUR   = DEF_PART_COLOUR
) (
  input  logic                   clock,
  input  logic                   clear,
  frame_draw_sequencer_if.slave  bus
);

  localparam logic [8:0] SCR_W  = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H  = 8'(SCREEN_H);
  localparam logic [8:0] PIS_W  = 9'(PISTON_W);
  localparam logic [8:0] PIS_X0 = 9'(PISTON_X0);
  localparam logic [8:0] PRT_W  = 9'(PART_SIZE);
  localparam logic [7:0] PRT_H  = 8'(PART_SIZE);

  state_t      state, state_nx;
  logic [7:0]  height_q;
  logic [26:0] part_x_q;
  logic [23:0] part_y_q;
  logic [7:0]  height_clamped;

  logic [8:0]  sx;
  logic [7:0]  sy;
  logic        last;
  logic [8:0]  scan_w;
  logic [7:0]  scan_h;
  logic        scan_restart;
  logic        scan_enable;

  logic [8:0]  part_px;
  logic [7:0]  part_py;
  logic [9:0]  sum_x;
  logic [8:0]  sum_y;
  logic        clipped;

  logic [8:0]  x_nx;
  logic [7:0]  y_nx;
  logic [2:0]  colour_nx;
  logic        plot_nx;
  logic        busy_nx;
  logic        done_nx;

  rect_scanner u_scanner (
    .clock   (clock),
    .clear   (clear),
    .restart (scan_restart),
    .enable  (scan_enable),
    .w       (scan_w),
    .h       (scan_h),
    .sx      (sx),
    .sy      (sy),
    .last    (last)
  );

  assign height_clamped = (bus.piston_height > SCR_H) ? SCR_H : bus.piston_height;

  always_comb begin
    part_px = part_x_q[8:0];
    part_py = part_y_q[7:0];
    case (state)
      ST_PART1: begin part_px = part_x_q[17:9];  part_py = part_y_q[15:8];  end
      ST_PART2: begin part_px = part_x_q[26:18]; part_py = part_y_q[23:16]; end
      default:  ;
    endcase
  end

  // Widened sums so off-screen pixels are detected instead of wrapping.
  assign sum_x   = {1'b0, part_px} + {1'b0, sx};
  assign sum_y   = {1'b0, part_py} + {1'b0, sy};
  assign clipped = (sum_x >= {1'b0, SCR_W}) || (sum_y >= {1'b0, SCR_H});

  always_ff @(posedge clock) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // The scanner always points at the pixel the output register loads next,
  // so IDLE+start already emits the first clear pixel at the accepting edge.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nx     = state;
    scan_w       = SCR_W;
    scan_h       = SCR_H;
    scan_restart = 1'b0;
    scan_enable  = 1'b0;
    x_nx         = '0;
    y_nx         = '0;
    colour_nx    = '0;
    plot_nx      = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx    = ST_CLEAR;
          scan_enable = 1'b1;
          x_nx        = sx;
          y_nx        = sy;
          colour_nx   = BG_COLOUR;
          plot_nx     = 1'b1;
          busy_nx     = 1'b1;
        end else begin
          scan_restart = 1'b1;
        end
      end
      ST_CLEAR: begin
        scan_enable = 1'b1;
        x_nx        = sx;
        y_nx        = sy;
        colour_nx   = BG_COLOUR;
        plot_nx     = 1'b1;
        busy_nx     = 1'b1;
        if (last) state_nx = (height_q == 8'd0) ? ST_PART0 : ST_PISTON;
      end
      ST_PISTON: begin
        scan_w      = PIS_W;
        scan_h      = height_q;
        scan_enable = 1'b1;
        x_nx        = PIS_X0 + sx;
        y_nx        = sy;
        colour_nx   = PISTON_COLOUR;
        plot_nx     = 1'b1;
        busy_nx     = 1'b1;
        if (last) state_nx = ST_PART0;
      end
      ST_PART0, ST_PART1, ST_PART2: begin
        scan_w      = PRT_W;
        scan_h      = PRT_H;
        scan_enable = 1'b1;
        x_nx        = sum_x[8:0];
        y_nx        = sum_y[7:0];
        colour_nx   = PART_COLOUR;
        plot_nx     = !clipped;
        busy_nx     = 1'b1;
        if (last) begin
          case (state)
            ST_PART0: state_nx = ST_PART1;
            ST_PART1: state_nx = ST_PART2;
            default:  state_nx = ST_DONE;
          endcase
        end
      end
      ST_DONE: begin
        done_nx  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      height_q <= '0;
      part_x_q <= '0;
      part_y_q <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      height_q <= height_clamped;
      part_x_q <= bus.part_x;
      part_y_q <= bus.part_y;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.x      <= x_nx;
      bus.y      <= y_nx;
      bus.colour <= colour_nx;
      bus.plot   <= plot_nx;
      bus.busy   <= busy_nx;
      bus.done   <= done_nx;
    end
  end

endmodule
